// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit geometry, packet length and port identifiers.
package noc_pkg;

    localparam int unsigned FLIT_W    = 32;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned PKT_FLITS = 4;
    localparam int unsigned IB_DEPTH  = 4;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_W = 3'd2,
        PORT_E = 3'd3,
        PORT_L = 3'd4
    } port_e;

    typedef logic [FLIT_W-1:0] flit_t;

endpackage : noc_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers/count; a pop frees its slot for a same-edge push.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             empty_c,
    output logic             full_c,
    output logic             push_ok_c,
    output logic             pop_ok_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Status decode and transfer qualification; no bypass path when empty.
    always_comb begin
        empty_c   = (count == '0);
        full_c    = (count == CNT_W'(DEPTH));
        pop_ok_c  = pop && !empty_c;
        push_ok_c = push && (!full_c || pop_ok_c);
        rd_data_c = empty_c ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok_c, pop_ok_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_ok_c) mem[wr_ptr] <= wr_data;
    end

endmodule : sync_fifo

// File: rtl/input_buffer.sv
// Router input port: FIFO plus packet-boundary tracking, head header extraction,
// credit return and sticky overflow detection.
module input_buffer #(
    parameter int unsigned FLIT_W    = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PKT_FLITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ib_write_i,
    input  logic [FLIT_W-1:0] ib_data_i,
    input  logic              ib_read_i,
    output logic [FLIT_W-1:0] ib_data_o,
    output logic              ib_empty_o,
    output logic              ib_full_o,
    output logic [15:0]       ib_addr_header_o,
    output logic              ib_header_valid_o,
    output logic              ib_credit_o,
    output logic              ib_overflow_o
);

    import noc_pkg::*;

    localparam int unsigned IDX_W = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;

    logic [FLIT_W-1:0] head_flit;
    logic              empty;
    logic              full;
    logic              push_ok;
    logic              pop_ok;
    logic [IDX_W-1:0]  flit_idx;
    logic              credit_q;
    logic              overflow_q;

    sync_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ib_write_i),
        .wr_data   (ib_data_i),
        .pop       (ib_read_i),
        .rd_data_c (head_flit),
        .empty_c   (empty),
        .full_c    (full),
        .push_ok_c (push_ok),
        .pop_ok_c  (pop_ok)
    );

    // Flit position within the current packet, advanced by pops; credit and overflow flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flit_idx   <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            credit_q <= pop_ok;
            if (ib_write_i && !push_ok) overflow_q <= 1'b1;
            if (pop_ok) begin
                if (flit_idx == IDX_W'(PKT_FLITS - 1)) flit_idx <= '0;
                else                                   flit_idx <= flit_idx + IDX_W'(1);
            end
        end
    end

    always_comb begin
        ib_data_o         = head_flit;
        ib_empty_o        = empty;
        ib_full_o         = full;
        ib_header_valid_o = !empty && (flit_idx == '0);
        ib_addr_header_o  = ib_header_valid_o ? head_flit[ADDR_W-1:0] : '0;
        ib_credit_o       = credit_q;
        ib_overflow_o     = overflow_q;
    end

endmodule : input_buffer
